// File: rtl/controle_mostra_sequencia.sv
// ============================================================================
// Module  : controle_mostra_sequencia
// Brief   : Plays the stored game sequence on the LEDs, sweeping the memory
//           read address from 0 up to a round limit latched at start.
// Revision: 1.0
// ============================================================================
`default_nettype none

module controle_mostra_sequencia #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int TMR_W  = 16,
   parameter int T_ON   = 1000,
   parameter int T_OFF  = 500
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   input  logic [ADDR_W-1:0] limite,
   input  logic [DATA_W-1:0] dado,
   output logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] leds,
   output logic              ocupado,
   output logic              pronto,
   output logic [3:0]        db_estado
);

   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      CARREGA = 4'd1,
      ACENDE  = 4'd2,
      APAGA   = 4'd3,
      PROXIMO = 4'd4,
      FIM     = 4'd5
   } state_t;

   localparam logic [TMR_W-1:0] c_ton_last  = TMR_W'(T_ON - 1);
   localparam logic [TMR_W-1:0] c_toff_last = TMR_W'(T_OFF - 1);

   state_t              r_state,    w_state;
   logic [ADDR_W-1:0]   r_endereco, w_endereco;
   logic [DATA_W-1:0]   r_leds,     w_leds;
   logic [TMR_W-1:0]    r_timer,    w_timer;
   logic [ADDR_W-1:0]   r_lim,      w_lim;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= OCIOSO;
         r_endereco <= '0;
         r_leds     <= '0;
         r_timer    <= '0;
         r_lim      <= '0;
      end else begin
         r_state    <= w_state;
         r_endereco <= w_endereco;
         r_leds     <= w_leds;
         r_timer    <= w_timer;
         r_lim      <= w_lim;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_endereco = r_endereco;
      w_leds     = r_leds;
      w_timer    = r_timer;
      w_lim      = r_lim;

      case (r_state)
         OCIOSO: begin
            w_endereco = '0;
            w_leds     = '0;
            w_timer    = '0;
            if (iniciar && !abortar) begin
               w_state = CARREGA;
               w_lim   = limite;
            end
         end
         CARREGA: begin
            w_leds  = dado;
            w_timer = '0;
            w_state = ACENDE;
         end
         ACENDE: begin
            if (r_timer == c_ton_last) begin
               w_leds  = '0;
               w_timer = '0;
               w_state = APAGA;
            end else begin
               w_timer = r_timer + TMR_W'(1);
            end
         end
         APAGA: begin
            // Compare before incrementing so the last address never wraps.
            if (r_timer == c_toff_last) begin
               w_timer = '0;
               w_state = (r_endereco == r_lim) ? FIM : PROXIMO;
            end else begin
               w_timer = r_timer + TMR_W'(1);
            end
         end
         PROXIMO: begin
            w_endereco = r_endereco + ADDR_W'(1);
            w_state    = CARREGA;
         end
         FIM: begin
            w_endereco = '0;
            w_state    = OCIOSO;
         end
         default: begin
            w_endereco = '0;
            w_leds     = '0;
            w_timer    = '0;
            w_state    = OCIOSO;
         end
      endcase

      // Abort overrides every transition, including the exit from FIM.
      if (abortar && (r_state != OCIOSO)) begin
         w_state    = OCIOSO;
         w_endereco = '0;
         w_leds     = '0;
         w_timer    = '0;
      end
   end

   assign endereco  = r_endereco;
   assign leds      = r_leds;
   assign db_estado = r_state;
   assign ocupado   = (r_state == CARREGA) || (r_state == ACENDE) ||
                      (r_state == APAGA)   || (r_state == PROXIMO);
   assign pronto    = (r_state == FIM);

endmodule

`default_nettype wire

// File: tb/tb_controle_mostra_sequencia.sv
// ============================================================================
// Module  : tb_controle_mostra_sequencia
// Brief   : Directed self-checking bench for controle_mostra_sequencia.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_controle_mostra_sequencia;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 4;
   localparam int TMR_W  = 16;
   localparam int T_ON   = 3;
   localparam int T_OFF  = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              iniciar;
   logic              abortar;
   logic [ADDR_W-1:0] limite;
   logic [DATA_W-1:0] dado;
   logic [ADDR_W-1:0] endereco;
   logic [DATA_W-1:0] leds;
   logic              ocupado;
   logic              pronto;
   logic [3:0]        db_estado;

   logic [DATA_W-1:0] mem [16];
   assign dado = mem[endereco];

   int n_tests = 0;
   int n_fail  = 0;

   // Cycle-by-cycle expectations for limite=2, T_ON=3, T_OFF=2, k=0 is CARREGA.
   logic [3:0] seq_leds  [22] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0,
                                  4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0,
                                  4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0] seq_addr  [22] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                                  4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
                                  4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0};
   logic [3:0] seq_state [22] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4,
                                  4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4,
                                  4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd5, 4'd0};

   controle_mostra_sequencia #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TMR_W  (TMR_W),
      .T_ON   (T_ON),
      .T_OFF  (T_OFF)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .abortar   (abortar),
      .limite    (limite),
      .dado      (dado),
      .endereco  (endereco),
      .leds      (leds),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .db_estado (db_estado)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic load_onehot();
      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
   endtask

   // Pulses iniciar for one edge; on return the bench sits at k=0 (CARREGA).
   task automatic start(input logic [ADDR_W-1:0] lim);
      limite  = lim;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; iniciar = 1'b0; abortar = 1'b0; limite = '0;
      load_onehot();
      tick(); tick();
      n_tests++;
      if ({db_estado, endereco, leds, ocupado, pronto} !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_state: estado=%0d end=%0d leds=%b ocu=%b pronto=%b, want all 0",
                  db_estado, endereco, leds, ocupado, pronto);
      end
      reset = 1'b1;
      tick();
      n_tests++;
      if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: estado=%0d ocu=%b, want 0/0", db_estado, ocupado);
      end
   endtask

   task automatic test_abort_idle();
      iniciar = 1'b1; abortar = 1'b1; limite = 4'd1;
      tick();
      n_tests++;
      if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_with_iniciar_idle: estado=%0d ocu=%b, want 0/0", db_estado, ocupado);
      end
      iniciar = 1'b0;
      tick();
      n_tests++;
      if (db_estado !== 4'd0) begin
         n_fail++;
         $display("FAIL abort_alone_idle: estado=%0d, want 0", db_estado);
      end
      abortar = 1'b0;
   endtask

   task automatic test_sequence();
      load_onehot();
      start(4'd2);
      for (int k = 0; k < 22; k++) begin
         n_tests++;
         if (leds !== seq_leds[k] || endereco !== seq_addr[k] || db_estado !== seq_state[k] ||
             ocupado !== (seq_state[k] inside {4'd1, 4'd2, 4'd3, 4'd4}) ||
             pronto !== (seq_state[k] == 4'd5)) begin
            n_fail++;
            $display("FAIL seq_k%0d: leds=%b end=%0d est=%0d ocu=%b pr=%b, want leds=%b end=%0d est=%0d",
                     k, leds, endereco, db_estado, ocupado, pronto, seq_leds[k], seq_addr[k], seq_state[k]);
         end
         if (k < 21) tick();
      end
   endtask

   task automatic test_limite_zero();
      load_onehot();
      start(4'd0);
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (leds !== ((k >= 1 && k <= 3) ? 4'b0001 : 4'b0000) || endereco !== 4'd0 ||
             pronto !== (k == 6) || ocupado !== (k <= 5)) begin
            n_fail++;
            $display("FAIL lim0_k%0d: leds=%b end=%0d pr=%b ocu=%b", k, leds, endereco, pronto, ocupado);
         end
         if (k < 7) tick();
      end
   endtask

   task automatic test_full_sweep();
      logic [3:0] e_leds;
      logic [3:0] e_addr;
      int e, ph;
      for (int i = 0; i < 16; i++) mem[i] = 4'(i) ^ 4'h5;
      start(4'd15);
      for (int k = 0; k < 113; k++) begin
         e  = k / 7;
         ph = k % 7;
         e_leds = (k < 111 && ph >= 1 && ph <= 3) ? (4'(e) ^ 4'h5) : 4'h0;
         e_addr = (k <= 111) ? 4'(e) : 4'd0;
         n_tests++;
         if (leds !== e_leds || endereco !== e_addr || pronto !== (k == 111)) begin
            n_fail++;
            $display("FAIL sweep_k%0d: leds=%h end=%0d pr=%b, want leds=%h end=%0d pr=%b",
                     k, leds, endereco, pronto, e_leds, e_addr, (k == 111));
         end
         if (k < 112) tick();
      end
   endtask

   task automatic test_abort();
      load_onehot();
      start(4'd2);
      for (int k = 0; k < 9; k++) tick();
      n_tests++;
      if (db_estado !== 4'd2 || leds !== 4'b0010) begin
         n_fail++;
         $display("FAIL abort_pre: est=%0d leds=%b, want 2/0010", db_estado, leds);
      end
      abortar = 1'b1;
      tick();
      abortar = 1'b0;
      n_tests++;
      if (db_estado !== 4'd0 || leds !== 4'h0 || endereco !== 4'd0 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_exit: est=%0d leds=%b end=%0d ocu=%b, want all 0",
                  db_estado, leds, endereco, ocupado);
      end
      for (int k = 0; k < 50; k++) begin
         tick();
         n_tests++;
         if (pronto !== 1'b0 || db_estado !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_quiet_%0d: pr=%b est=%0d, want 0/0", k, pronto, db_estado);
         end
      end
   endtask

   task automatic test_async_reset_and_ignore();
      load_onehot();
      start(4'd2);
      for (int k = 0; k < 4; k++) tick();
      n_tests++;
      if (db_estado !== 4'd3) begin
         n_fail++;
         $display("FAIL rst_pre_apaga: est=%0d, want 3", db_estado);
      end
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if ({db_estado, endereco, leds, ocupado, pronto} !== 14'h0) begin
         n_fail++;
         $display("FAIL async_reset: est=%0d end=%0d leds=%b ocu=%b pr=%b, want all 0",
                  db_estado, endereco, leds, ocupado, pronto);
      end
      tick();
      reset = 1'b1;
      tick();
      n_tests++;
      if (pronto !== 1'b0 || db_estado !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_release: pr=%b est=%0d, want 0/0", pronto, db_estado);
      end
      // limite changes and iniciar pulses during playback must be ignored
      start(4'd1);
      for (int k = 0; k < 17; k++) begin
         if (k == 2) limite = 4'd3;
         if (k == 3) iniciar = 1'b1;
         if (k == 4) iniciar = 1'b0;
         n_tests++;
         if (pronto !== (k == 13) || (k == 13 && endereco !== 4'd1) ||
             (k >= 14 && db_estado !== 4'd0)) begin
            n_fail++;
            $display("FAIL ignore_k%0d: pr=%b end=%0d est=%0d", k, pronto, endereco, db_estado);
         end
         if (k < 16) tick();
      end
   endtask

   task automatic test_back_to_back();
      load_onehot();
      limite  = 4'd1;
      iniciar = 1'b1;
      tick();
      for (int k = 0; k < 31; k++) begin
         if (k == 29) iniciar = 1'b0;
         n_tests++;
         if (pronto !== (k == 13 || k == 28) ||
             (k == 14 && db_estado !== 4'd0) || (k == 15 && db_estado !== 4'd1) ||
             (k == 30 && db_estado !== 4'd0)) begin
            n_fail++;
            $display("FAIL b2b_k%0d: pr=%b est=%0d", k, pronto, db_estado);
         end
         if (k < 30) tick();
      end
   endtask

   initial begin
      test_reset();
      test_abort_idle();
      test_sequence();
      test_limite_zero();
      test_full_sweep();
      test_abort();
      test_async_reset_and_ignore();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
